round_robin_arbiter_fixed_time_slices: RTL and testbench

- N-requester round-robin arbiter; each winner holds a one-hot grant for a fixed time slice of SLICE_LEN cycles.
- A winner that drops its request before the slice ends gives up the grant early.
- Sits in front of a shared resource (bus/switch port); requesters hold REQ high while they want service and use GNT as their ownership qualifier.

---
 rtl/round_robin_arbiter_fixed_time_slices_pkg.sv | 16 +
 rtl/round_robin_arbiter_fixed_time_slices_if.sv | 10 +
 rtl/round_robin_arbiter_fixed_time_slices_picker.sv | 37 +++
 rtl/round_robin_arbiter_fixed_time_slices.sv | 69 ++++++
 tb/tb_round_robin_arbiter_fixed_time_slices.sv | 127 ++++++++++++
 5 files changed

// File: rtl/round_robin_arbiter_fixed_time_slices_pkg.sv
// Shared constants and width helpers for the time-sliced round-robin arbiter.
package arb_pkg;

    localparam int N_DEF         = 4;
    localparam int SLICE_LEN_DEF = 4;

    // Slice counter only needs to reach SLICE_LEN-1; keep at least one bit.
    function automatic int cnt_width(input int slice_len);
        return (slice_len <= 1) ? 1 : $clog2(slice_len);
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/round_robin_arbiter_fixed_time_slices_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface round_robin_arbiter_fixed_time_slices_if #(
    parameter int N = 4
);
    logic [N-1:0] REQ;
    logic [N-1:0] GNT;

    modport master (output REQ, input GNT);
    modport slave  (input REQ, output GNT);
endinterface

// File: rtl/round_robin_arbiter_fixed_time_slices_picker.sv
// Combinational wrap-around scan: first set request starting just after last.
module rr_next_picker #(
    parameter int N  = 4,
    parameter int LW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic          valid,
    output logic [N-1:0]  winner,
    output logic [LW-1:0] winner_idx
);

    logic [N-1:0]  rot_req;
    logic [LW-1:0] rot_idx [N];

    // rot_req[k] is the request seen k+1 positions after last, so last itself is scanned final.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot_idx[gi] = LW'((int'(last) + 1 + gi) % N);
        assign rot_req[gi] = req[rot_idx[gi]];
    end

    always_comb begin
        valid      = 1'b0;
        winner     = '0;
        winner_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                valid      = 1'b1;
                winner_idx = rot_idx[k];
            end
        end
        if (valid) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/round_robin_arbiter_fixed_time_slices.sv
// Round-robin arbiter granting each winner up to SLICE_LEN consecutive cycles.
module round_robin_arbiter_fixed_time_slices
    import arb_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int SLICE_LEN = SLICE_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    round_robin_arbiter_fixed_time_slices_if.slave bus
);

    localparam int CW = cnt_width(SLICE_LEN);
    localparam int LW = idx_width(N);

    logic [N-1:0]  gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] last_q, last_d;

    logic          pick_valid;
    logic [N-1:0]  pick_winner;
    logic [LW-1:0] pick_idx;
    logic          owner_req;

    rr_next_picker #(
        .N  (N),
        .LW (LW)
    ) u_picker (
        .req        (bus.REQ),
        .last       (last_q),
        .valid      (pick_valid),
        .winner     (pick_winner),
        .winner_idx (pick_idx)
    );

    // gnt_q is one-hot or zero, so this is REQ[owner] gated by ownership.
    assign owner_req = |(gnt_q & bus.REQ);

    always_comb begin
        gnt_d  = gnt_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (owner_req && (int'(cnt_q) < SLICE_LEN - 1)) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pick_valid) begin
            gnt_d  = pick_winner;
            last_d = pick_idx;
            cnt_d  = '0;
        end else begin
            gnt_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= '0;
            cnt_q  <= '0;
            last_q <= LW'(N - 1);
        end else begin
            gnt_q  <= gnt_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign bus.GNT = gnt_q;

endmodule

// File: tb/tb_round_robin_arbiter_fixed_time_slices.sv
// Self-checking bench: vector table plus hand-written fairness and mid-slice reset sequences.
module tb_round_robin_arbiter_fixed_time_slices;

    localparam int N  = 4;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    round_robin_arbiter_fixed_time_slices_if #(.N(N)) bus ();

    round_robin_arbiter_fixed_time_slices #(
        .N         (N),
        .SLICE_LEN (SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
    } vec_t;

    vec_t         tbl[$];
    logic [N-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    function automatic vec_t mk(input logic r, input logic [N-1:0] q, input logic [N-1:0] g);
        vec_t v;
        v.rst = r;
        v.req = q;
        v.gnt = g;
        return v;
    endfunction

    // Drive one edge worth of stimulus, queue the expected grant, compare after the edge.
    task automatic step(input logic r, input logic [N-1:0] req, input logic [N-1:0] exp_gnt,
                        input string name);
        logic [N-1:0] e;
        rst     = r;
        bus.REQ = req;
        exp_q.push_back(exp_gnt);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.GNT !== e) begin
            n_bad++;
            $display("FAIL %s: rst=%b REQ=%b GNT=%b expected %b", name, r, req, bus.GNT, e);
        end else begin
            $display("ok   %s: rst=%b REQ=%b GNT=%b", name, r, req, bus.GNT);
        end
    endtask

    initial begin
        // reset and idle
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000));
        tbl.push_back(mk(1'b1, 4'b1111, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000));
        // sole requester 3: granted, held 4, re-granted without a gap
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b1000, 4'b1000));
        tbl.push_back(mk(1'b0, 4'b1000, 4'b1000));
        tbl.push_back(mk(1'b0, 4'b1000, 4'b1000));
        tbl.push_back(mk(1'b0, 4'b1000, 4'b1000));
        tbl.push_back(mk(1'b0, 4'b1000, 4'b1000));
        // requester 1 joins mid-slice; waits for expiry, then wraps 3->0->1
        tbl.push_back(mk(1'b0, 4'b1010, 4'b1000));
        tbl.push_back(mk(1'b0, 4'b1010, 4'b1000));
        tbl.push_back(mk(1'b0, 4'b1010, 4'b1000));
        tbl.push_back(mk(1'b0, 4'b1010, 4'b0010));
        // owner 1 drops early
        tbl.push_back(mk(1'b0, 4'b0100, 4'b0100));
        tbl.push_back(mk(1'b0, 4'b0100, 4'b0100));
        // last=1 from idle, then successive early releases to idle
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0010));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b0110, 4'b0100));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0010));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0001));
        tbl.push_back(mk(1'b0, 4'b1001, 4'b0001));
        tbl.push_back(mk(1'b0, 4'b1000, 4'b1000));

        rst     = 1'b1;
        bus.REQ = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].gnt, $sformatf("vec%0d", i));
        end

        // reset mid-slice restores last=N-1, so requester 0 beats 3 afterwards
        step(1'b1, 4'b0000, 4'b0000, "mid_rst_pre");
        step(1'b0, 4'b0100, 4'b0100, "mid_rst_grant");
        step(1'b0, 4'b0100, 4'b0100, "mid_rst_hold");
        step(1'b1, 4'b1001, 4'b0000, "mid_rst_assert");
        step(1'b0, 4'b1001, 4'b0001, "mid_rst_after");

        // all requesting: SL cycles each, in order 0,1,2,3,0
        step(1'b1, 4'b0000, 4'b0000, "fair_rst");
        for (int c = 0; c < 5 * SL; c++) begin
            logic [N-1:0] e;
            e = '0;
            e[(c / SL) % N] = 1'b1;
            step(1'b0, 4'b1111, e, $sformatf("fair%0d", c));
            n_cmp++;
            if (!$onehot(bus.GNT)) begin
                n_bad++;
                $display("FAIL fair_onehot%0d: GNT=%b required one-hot", c, bus.GNT);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
